// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_pkg;

  // Default operand/result width; the iteration count equals this width.
  localparam int WIDTH_DEF = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth decode of the {Q[0], q_1} pair.
  localparam logic [1:0] BOOTH_HOLD0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD   = 2'b01;
  localparam logic [1:0] BOOTH_SUB   = 2'b10;
  localparam logic [1:0] BOOTH_HOLD1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration over {A, Q, q_1}:
// add/subtract/hold M into A, then arithmetic shift right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  // Booth add/sub/hold followed by the arithmetic shift of the whole triple.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sum = a;
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: one signed iteration per clock,
// returning the low word of the product plus a signed-overflow flag.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_next;
  logic [WIDTH:0]   a, m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q_1_next;

  logic accept;
  logic last;

  // A new operation is taken whenever the unit is not iterating.
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (count == CW'(WIDTH - 1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .a_next   (a_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: DONE may chain straight into RUN on a new start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: load on accept, iterate in RUN, capture result on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      m        <= '0;
      count    <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      a     <= '0;
      q     <= multiplier;
      q_1   <= 1'b0;
      m     <= {multiplicand[WIDTH-1], multiplicand};
      count <= '0;
    end else if (state == RUN) begin
      a     <= a_next;
      q     <= q_next;
      q_1   <= q_1_next;
      count <= count + CW'(1);
      if (last) begin
        result   <= q_next;
        // The product fits in WIDTH signed bits only if the high word is a pure sign extension.
        overflow <= (a_next[WIDTH-1:0] != {WIDTH{q_next[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed corner cases plus random
// operands compared against a plain-arithmetic product model.
module tb_booth_mult;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  booth_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full signed product in 64-bit arithmetic.
  function automatic void model(input logic [W-1:0] m, input logic [W-1:0] q,
                                output logic [W-1:0] r, output logic o);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    r = p[W-1:0];
    o = (p != longint'($signed(r)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after edge k+first; returns edge offset of done (-1 on timeout).
  task automatic wait_done(input int first, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = first; i < first + 2 * W; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      tick();
    end
  endtask

  // Accept an operation (must be called #1 after an edge, in IDLE or DONE).
  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q);
    int lat, bcnt;
    logic [W-1:0] er;
    logic eo;
    launch(m, q);
    wait_done(0, lat, bcnt);
    model(m, q, er, eo);
    check({tag, "_latency"}, 64'(lat), 64'(W));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(W));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_overflow"}, 64'(overflow), 64'(eo));
  endtask

  // Watch for a stray done pulse over a window.
  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) seen++;
      tick();
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat, bcnt;
    logic [W-1:0] mm, qq, er;
    logic eo;

    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    tick();
    tick();
    check("reset_outputs", {busy, done, overflow, result}, '0);
    rst_n = 1'b1;
    tick();
    check("idle_outputs", {busy, done}, '0);

    // Directed cases.
    run_op("pos_3x5", 32'd3, 32'd5);
    check("pos_3x5_value", 64'(result), 64'd15);
    tick();
    run_op("neg7x6", 32'hFFFF_FFF9, 32'd6);
    check("neg7x6_value", 64'(result), 64'hFFFF_FFD6);
    tick();
    run_op("neg7xneg6", 32'hFFFF_FFF9, 32'hFFFF_FFFA);
    check("neg7xneg6_value", 64'(result), 64'd42);
    tick();
    run_op("max_x2", 32'h7FFF_FFFF, 32'd2);
    check("max_x2_ovf", {overflow, result}, {1'b1, 32'hFFFF_FFFE});
    tick();
    run_op("min_xneg1", 32'h8000_0000, 32'hFFFF_FFFF);
    check("min_xneg1_ovf", {overflow, result}, {1'b1, 32'h8000_0000});
    tick();
    run_op("min_x1", 32'h8000_0000, 32'd1);
    check("min_x1_ovf", {overflow, result}, {1'b0, 32'h8000_0000});
    tick();
    run_op("min_xmin", 32'h8000_0000, 32'h8000_0000);
    tick();

    // Start during RUN is ignored; result holds its old value meanwhile.
    launch(32'd4, 32'd4);
    for (int i = 1; i < 10; i++) tick();
    check("hold_during_run", 64'(result), 64'h0);
    start        = 1'b1;
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    tick();
    start = 1'b0;
    wait_done(10, lat, bcnt);
    check("ignored_start_latency", 64'(lat), 64'(W));
    check("ignored_start_result", 64'(result), 64'd16);
    tick();
    no_done("ignored_start_no_extra_done", 2 * W);

    // Back-to-back: new start presented in the DONE cycle.
    run_op("b2b_first", 32'd10, 32'd10);
    check("b2b_first_value", 64'(result), 64'd100);
    launch(32'd2, 32'd3);
    check("b2b_busy_next", 64'(busy), 64'd1);
    wait_done(0, lat, bcnt);
    check("b2b_second_latency", 64'(lat), 64'(W));
    check("b2b_second_result", 64'(result), 64'd6);
    tick();

    // Asynchronous reset in the middle of RUN.
    launch(32'd123, 32'd456);
    for (int i = 1; i < 15; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, overflow, result}, '0);
    tick();
    rst_n = 1'b1;
    no_done("reset_no_done", 2 * W);
    run_op("after_reset", 32'd1, 32'hFFFF_FFFF);
    check("after_reset_value", {overflow, result}, {1'b0, 32'hFFFF_FFFF});
    tick();

    // Random operands, mixing full-range and small values; some back-to-back.
    for (int n = 0; n < 24; n++) begin
      mm = $urandom;
      qq = $urandom;
      if ($urandom_range(0, 3) == 0) mm = W'($signed(32'($urandom_range(0, 31)) - 32'd16));
      if ($urandom_range(0, 3) == 0) qq = W'($signed(32'($urandom_range(0, 31)) - 32'd16));
      run_op($sformatf("rand%0d", n), mm, qq);
      if ($urandom_range(0, 1) == 0) tick();
    end

    // Result persists unchanged after returning to IDLE.
    model(mm, qq, er, eo);
    tick();
    tick();
    check("hold_in_idle", {overflow, result}, {eo, er});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
